overflow_arith_pipe: RTL and testbench

OVERFLOW_ARITH_PIPE -- requirements
Module: overflow_arith_pipe

---
 rtl/overflow_arith_pipe.sv | 134 +++++++++++++
 tb/tb_overflow_arith_pipe.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/overflow_arith_pipe.sv
// Two-stage add/subtract pipeline with signed-overflow, carry, sticky flag and a saturating overflow counter.
// Optional macro OVERFLOW_SATURATE_EN clamps s on overflow instead of wrapping.
module overflow_arith_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clr_sticky,
  output logic             out_valid,
  output logic [WIDTH-1:0] s,
  output logic             v,
  output logic             c,
  output logic             v_sticky,
  output logic [CNT_W-1:0] ovf_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Signed overflow: operands agree in sign but the result does not.
  function automatic logic add_ovf(input logic sign_a, input logic sign_b, input logic sign_r);
    return (sign_a == sign_b) && (sign_r != sign_a);
  endfunction

  logic             vld1_r;
  logic             sub1_r;
  logic [WIDTH-1:0] a1_r;
  logic [WIDTH-1:0] b1_r;

  logic [WIDTH-1:0] eff_b_s;
  logic [WIDTH:0]   sum_s;
  logic             ovf_s;
  logic [WIDTH-1:0] res_s;
  logic             event_s;

  // Stage 1: capture the request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld1_r <= 1'b0;
      sub1_r <= 1'b0;
      a1_r   <= {WIDTH{1'b0}};
      b1_r   <= {WIDTH{1'b0}};
    end else begin
      vld1_r <= in_valid;
      if (in_valid) begin
        sub1_r <= sub;
        a1_r   <= a;
        b1_r   <= b;
      end else begin
        sub1_r <= sub1_r;
        a1_r   <= a1_r;
        b1_r   <= b1_r;
      end
    end
  end

  // Stage 2 arithmetic: subtraction is a + ~b + 1 so carry means "no borrow".
  always_comb begin
    eff_b_s = b1_r;
    sum_s   = {(WIDTH+1){1'b0}};
    ovf_s   = 1'b0;
    res_s   = {WIDTH{1'b0}};
    if (sub1_r) begin
      eff_b_s = ~b1_r;
    end else begin
      eff_b_s = b1_r;
    end
    sum_s = {1'b0, a1_r} + {1'b0, eff_b_s} + {{WIDTH{1'b0}}, sub1_r};
    ovf_s = add_ovf(a1_r[WIDTH-1], eff_b_s[WIDTH-1], sum_s[WIDTH-1]);
`ifdef OVERFLOW_SATURATE_EN
    if (ovf_s && !a1_r[WIDTH-1]) begin
      res_s = {1'b0, {(WIDTH-1){1'b1}}};
    end else if (ovf_s) begin
      res_s = {1'b1, {(WIDTH-1){1'b0}}};
    end else begin
      res_s = sum_s[WIDTH-1:0];
    end
`else
    res_s = sum_s[WIDTH-1:0];
`endif
  end

  // Stage 2 registers: results hold their last valid value between operations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      s         <= {WIDTH{1'b0}};
      v         <= 1'b0;
      c         <= 1'b0;
    end else begin
      out_valid <= vld1_r;
      if (vld1_r) begin
        s <= res_s;
        v <= ovf_s;
        c <= sum_s[WIDTH];
      end else begin
        s <= s;
        v <= v;
        c <= c;
      end
    end
  end

  assign event_s = out_valid & v;

  // Overflow history: a reported overflow wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_sticky  <= 1'b0;
      ovf_count <= {CNT_W{1'b0}};
    end else if (event_s) begin
      v_sticky <= 1'b1;
      if (clr_sticky) begin
        ovf_count <= CNT_ONE;
      end else if (ovf_count != CNT_MAX) begin
        ovf_count <= ovf_count + CNT_ONE;
      end else begin
        ovf_count <= ovf_count;
      end
    end else if (clr_sticky) begin
      v_sticky  <= 1'b0;
      ovf_count <= {CNT_W{1'b0}};
    end else begin
      v_sticky  <= v_sticky;
      ovf_count <= ovf_count;
    end
  end

endmodule

// File: tb/tb_overflow_arith_pipe.sv
// Scoreboard bench for overflow_arith_pipe (WIDTH=8, CNT_W=2); expected results come from signed integer arithmetic.
module tb_overflow_arith_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             clr_sticky;
  logic             out_valid;
  logic [WIDTH-1:0] s;
  logic             v;
  logic             c;
  logic             v_sticky;
  logic [CNT_W-1:0] ovf_count;

  overflow_arith_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub), .a(a), .b(b),
    .clr_sticky(clr_sticky), .out_valid(out_valid), .s(s), .v(v), .c(c),
    .v_sticky(v_sticky), .ovf_count(ovf_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [7:0] s;
    logic       v;
    logic       c;
  } exp_t;

  exp_t q[$];
  int   nvec  = 0;
  int   nfail = 0;

  logic [7:0] cur_s;
  logic       cur_v, cur_c, exp_ov, p1, prev_ev, m_sticky;
  logic [1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic op_sub, input logic [7:0] x, input logic [7:0] y);
    exp_t e;
    int r;
    r = op_sub ? ($signed(x) - $signed(y)) : ($signed(x) + $signed(y));
    e.v = (r > 127) || (r < -128);
    e.c = op_sub ? (x >= y) : ((int'(x) + int'(y)) > 255);
`ifdef OVERFLOW_SATURATE_EN
    if (r > 127)       e.s = 8'h7F;
    else if (r < -128) e.s = 8'h80;
    else               e.s = r[7:0];
`else
    e.s = r[7:0];
`endif
    return e;
  endfunction

  task automatic model_reset();
    q.delete();
    cur_s = 8'h00; cur_v = 1'b0; cur_c = 1'b0;
    exp_ov = 1'b0; p1 = 1'b0; prev_ev = 1'b0;
    m_sticky = 1'b0; m_cnt = 2'd0;
  endtask

  // One clock: drive at negedge, model the edge, check at the following negedge.
  task automatic cyc(input logic iv, input logic isub, input logic [7:0] ia,
                     input logic [7:0] ib, input logic iclr);
    exp_t e;
    in_valid = iv; sub = isub; a = ia; b = ib; clr_sticky = iclr;
    if (iv) q.push_back(model(isub, ia, ib));
    @(posedge clk);
    if (prev_ev) begin
      m_sticky = 1'b1;
      if (iclr) m_cnt = 2'd1;
      else if (m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
    end else if (iclr) begin
      m_sticky = 1'b0;
      m_cnt = 2'd0;
    end
    exp_ov = p1;
    p1 = iv;
    @(negedge clk);
    chk("out_valid", {31'd0, out_valid}, {31'd0, exp_ov});
    if (exp_ov) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        cur_s = e.s; cur_v = e.v; cur_c = e.c;
      end else begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end
    end
    chk("s", {24'd0, s}, {24'd0, cur_s});
    chk("v", {31'd0, v}, {31'd0, cur_v});
    chk("c", {31'd0, c}, {31'd0, cur_c});
    chk("v_sticky", {31'd0, v_sticky}, {31'd0, m_sticky});
    chk("ovf_count", {30'd0, ovf_count}, {30'd0, m_cnt});
    prev_ev = exp_ov && cur_v;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_s"}, {24'd0, s}, 32'd0);
    chk({tag, "_v"}, {31'd0, v}, 32'd0);
    chk({tag, "_c"}, {31'd0, c}, 32'd0);
    chk({tag, "_v_sticky"}, {31'd0, v_sticky}, 32'd0);
    chk({tag, "_ovf_count"}, {30'd0, ovf_count}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sub = 1'b0; a = 8'h00; b = 8'h00; clr_sticky = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;

    // Directed corner cases, issued back-to-back with mixed operations.
    cyc(1'b1, 1'b0, 8'h7F, 8'h01, 1'b0);
    cyc(1'b1, 1'b0, 8'h81, 8'hFE, 1'b0);
    cyc(1'b1, 1'b0, 8'h01, 8'h7E, 1'b0);
    cyc(1'b1, 1'b1, 8'h80, 8'h01, 1'b0);
    cyc(1'b1, 1'b1, 8'h05, 8'h07, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 8'hAA, 8'h55, 1'b0);
    chk("sticky_after_corners", {31'd0, v_sticky}, 32'd1);

    // Clear alone, then five overflows saturate the 2-bit counter.
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("clear_alone_count", {30'd0, ovf_count}, 32'd0);
    cyc(1'b1, 1'b0, 8'h7F, 8'h7F, 1'b0);
    cyc(1'b1, 1'b0, 8'h80, 8'h80, 1'b0);
    cyc(1'b1, 1'b1, 8'h80, 8'h7F, 1'b0);
    cyc(1'b1, 1'b1, 8'h7F, 8'h80, 1'b0);
    cyc(1'b1, 1'b0, 8'h40, 8'h40, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    chk("count_saturated", {30'd0, ovf_count}, 32'd3);

    // Clear coincident with a reported overflow, then clear alone.
    cyc(1'b1, 1'b0, 8'h7F, 8'h01, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("clr_vs_event_count", {30'd0, ovf_count}, 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b1);
    chk("clr_alone_sticky", {31'd0, v_sticky}, 32'd0);

    // Random traffic with sparse clears.
    for (int i = 0; i < 40; i++) begin
      cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
          8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 7) == 0));
    end
    repeat (2) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // Reset between edges with operations in flight.
    cyc(1'b1, 1'b0, 8'h7F, 8'h01, 1'b0);
    cyc(1'b1, 1'b0, 8'h81, 8'hFE, 1'b0);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    #1 rst_n = 1'b1;
    model_reset();
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    // First operation after reset is accepted.
    cyc(1'b1, 1'b1, 8'h05, 8'h07, 1'b0);
    repeat (3) cyc(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
